// File: rtl/tff_bank_counter_pkg.sv
// Shared types and helpers for the T-flip-flop register bank: mode encoding
// and the load saturation function.
package tff_pkg;

  typedef enum logic [1:0] {
    TFF_TOGGLE = 2'b00,
    TFF_UP     = 2'b01,
    TFF_DOWN   = 2'b10,
    TFF_LOAD   = 2'b11
  } tff_mode_e;

  // Clamp a load value to the top of the count range.
  function automatic logic [31:0] sat_to_max(input logic [31:0] value,
                                             input logic [31:0] max);
    return (value > max) ? max : value;
  endfunction

endpackage

// File: rtl/tff_bank_counter_if.sv
// Control/data bundle of the T-flip-flop bank: the master drives the command,
// the slave (the bank) returns state and the terminal-count pulse.
interface tff_bank_counter_if #(
    parameter int WIDTH = 4
);
    import tff_pkg::*;

    logic             ena;
    tff_mode_e        mode;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             tc;

    modport master (output ena, mode, t, d, input  q, tc);
    modport slave  (input  ena, mode, t, d, output q, tc);

endinterface

// File: rtl/tff_bank_counter_cell.sv
// One T flip-flop cell: synchronous reset to a per-cell value, flips when
// enabled and its toggle bit is set.
module tff_cell (
    input  logic clk,
    input  logic reset,
    input  logic ena,
    input  logic tog,
    input  logic rst_val,
    output logic q
);

    // NOTE: sequential state uses non-blocking assignment so every cell samples
    // the same pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk) begin
        if (reset)
            q <= rst_val;
        else if (ena)
            q <= q ^ tog;
    end

endmodule

// File: rtl/tff_bank_counter.sv
// Parametrised register bank of T-flip-flop cells with toggle, modulo up/down
// count and saturating (optionally inverting) parallel load.
module tff_bank_counter
    import tff_pkg::*;
#(
    parameter int               WIDTH       = 4,
    parameter longint unsigned  MODULUS     = 64'd1 << WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0,
    parameter bit               INVERT_LOAD = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    tff_bank_counter_if.slave   bus
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 64'd1);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] tog;
    logic [WIDTH-1:0] load_val;
    logic             tc_next;
    logic             tc_q;

    assign load_val = INVERT_LOAD ? ~bus.d : bus.d;

    // NOTE: every output of this block gets a default first, so no path through
    // the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        q_next  = q;
        tc_next = 1'b0;
        if (bus.ena) begin
            unique case (bus.mode)
                TFF_TOGGLE: q_next = q ^ bus.t;
                TFF_UP: begin
                    if (q >= MAX) begin
                        q_next  = '0;
                        tc_next = 1'b1;
                    end else begin
                        q_next = q + WIDTH'(1);
                    end
                end
                TFF_DOWN: begin
                    if (q == '0) begin
                        q_next  = MAX;
                        tc_next = 1'b1;
                    end else if (q > MAX) begin
                        // Out-of-range recovery is silent: not a real wrap.
                        q_next = MAX;
                    end else begin
                        q_next = q - WIDTH'(1);
                    end
                end
                TFF_LOAD: q_next = WIDTH'(sat_to_max(32'(load_val), 32'(MAX)));
                default:  q_next = q;
            endcase
        end
    end

    // Each cell only sees which bits must flip; the arithmetic stays up here.
    assign tog = q ^ q_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clk     (clk),
            .reset   (reset),
            .ena     (bus.ena),
            .tog     (tog[i]),
            .rst_val (RESET_VAL[i]),
            .q       (q[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset)
            tc_q <= 1'b0;
        else
            tc_q <= tc_next;
    end

    assign bus.q  = q;
    assign bus.tc = tc_q;

endmodule

// File: tb/tb_tff_bank_counter.sv
// Directed bench for tff_bank_counter: three configurations driven from
// hand-computed vector tables plus a full-range toggle-pattern sequence.
module tb_tff_bank_counter;
    import tff_pkg::*;

    typedef struct {
        string     name;
        logic      rst;
        logic      ena;
        tff_mode_e mode;
        logic [3:0] t;
        logic [3:0] d;
        logic [3:0] exp_q;
        logic      exp_tc;
    } vec_t;

    logic clk = 1'b0;
    logic reset_a = 1'b0, reset_b = 1'b0, reset_c = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    tff_bank_counter_if #(.WIDTH(4)) if_a ();
    tff_bank_counter_if #(.WIDTH(4)) if_b ();
    tff_bank_counter_if #(.WIDTH(3)) if_c ();

    tff_bank_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(4'd0), .INVERT_LOAD(1'b1))
        dut_a (.clk(clk), .reset(reset_a), .bus(if_a.slave));
    tff_bank_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(4'd0), .INVERT_LOAD(1'b0))
        dut_b (.clk(clk), .reset(reset_b), .bus(if_b.slave));
    tff_bank_counter #(.WIDTH(3), .MODULUS(8), .RESET_VAL(3'd0), .INVERT_LOAD(1'b1))
        dut_c (.clk(clk), .reset(reset_c), .bus(if_c.slave));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic rst, input logic ena,
                                input tff_mode_e mode, input logic [3:0] t,
                                input logic [3:0] d, input logic [3:0] exp_q,
                                input logic exp_tc);
        vec_t v;
        v.name = name; v.rst = rst; v.ena = ena; v.mode = mode;
        v.t = t; v.d = d; v.exp_q = exp_q; v.exp_tc = exp_tc;
        return v;
    endfunction

    // Drive at the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input int sel, input vec_t v, input int idx);
        logic [3:0] act_q;
        logic       act_tc;
        @(negedge clk);
        case (sel)
            0: begin reset_a = v.rst; if_a.ena = v.ena; if_a.mode = v.mode;
                     if_a.t = v.t; if_a.d = v.d; end
            1: begin reset_b = v.rst; if_b.ena = v.ena; if_b.mode = v.mode;
                     if_b.t = v.t; if_b.d = v.d; end
            default: begin reset_c = v.rst; if_c.ena = v.ena; if_c.mode = v.mode;
                     if_c.t = v.t[2:0]; if_c.d = v.d[2:0]; end
        endcase
        @(posedge clk);
        #1;
        case (sel)
            0:       begin act_q = if_a.q;         act_tc = if_a.tc; end
            1:       begin act_q = if_b.q;         act_tc = if_b.tc; end
            default: begin act_q = {1'b0, if_c.q}; act_tc = if_c.tc; end
        endcase
        check($sformatf("%s[%0d].q", v.name, idx), 32'(act_q), 32'(v.exp_q));
        check($sformatf("%s[%0d].tc", v.name, idx), 32'(act_tc), 32'(v.exp_tc));
    endtask

    vec_t va[$];
    vec_t vb[$];

    initial begin
        logic [2:0] prev_q, cur_q, exp_tog;

        if_a.ena = 1'b0; if_a.mode = TFF_UP; if_a.t = '0; if_a.d = '0;
        if_b.ena = 1'b0; if_b.mode = TFF_UP; if_b.t = '0; if_b.d = '0;
        if_c.ena = 1'b0; if_c.mode = TFF_UP; if_c.t = '0; if_c.d = '0;

        // Config A: WIDTH=4, MODULUS=10 (MAX=9), inverting load.
        va.push_back(mk("a_reset", 1, 0, TFF_UP, 0, 0, 0, 0));
        for (int i = 1; i <= 12; i++)
            va.push_back(mk("a_up", 0, 1, TFF_UP, 0, 0, 4'(i % 10), (i == 10)));
        va.push_back(mk("a_load0", 0, 1, TFF_LOAD, 0, 4'hF, 0, 0));
        va.push_back(mk("a_down", 0, 1, TFF_DOWN, 0, 0, 9, 1));
        va.push_back(mk("a_down", 0, 1, TFF_DOWN, 0, 0, 8, 0));
        va.push_back(mk("a_down", 0, 1, TFF_DOWN, 0, 0, 7, 0));
        va.push_back(mk("a_tog_f", 0, 1, TFF_TOGGLE, 4'hF, 0, 8, 0));
        va.push_back(mk("a_up9", 0, 1, TFF_UP, 0, 0, 9, 0));
        va.push_back(mk("a_tog_5", 0, 1, TFF_TOGGLE, 4'h5, 0, 12, 0));
        va.push_back(mk("a_up_oor", 0, 1, TFF_UP, 0, 0, 0, 1));
        va.push_back(mk("a_load9", 0, 1, TFF_LOAD, 0, 4'b0110, 9, 0));
        va.push_back(mk("a_tog_5b", 0, 1, TFF_TOGGLE, 4'h5, 0, 12, 0));
        va.push_back(mk("a_down_oor", 0, 1, TFF_DOWN, 0, 0, 9, 0));
        va.push_back(mk("a_load3", 0, 1, TFF_LOAD, 0, 4'b1100, 3, 0));
        va.push_back(mk("a_load_sat", 0, 1, TFF_LOAD, 0, 4'b0000, 9, 0));
        va.push_back(mk("a_wrap", 0, 1, TFF_UP, 0, 0, 0, 1));
        va.push_back(mk("a_ena0_tc", 0, 0, TFF_UP, 0, 0, 0, 0));
        va.push_back(mk("a_load5", 0, 1, TFF_LOAD, 0, 4'b1010, 5, 0));
        for (int i = 0; i < 5; i++)
            va.push_back(mk("a_hold", 0, 0, TFF_UP, 0, 0, 5, 0));
        va.push_back(mk("a_up6", 0, 1, TFF_UP, 0, 0, 6, 0));
        va.push_back(mk("a_up7", 0, 1, TFF_UP, 0, 0, 7, 0));
        va.push_back(mk("a_mid_rst", 1, 1, TFF_UP, 0, 0, 0, 0));
        va.push_back(mk("a_resume", 0, 1, TFF_UP, 0, 0, 1, 0));
        va.push_back(mk("a_load9b", 0, 1, TFF_LOAD, 0, 4'b0110, 9, 0));
        va.push_back(mk("a_rst_wrap", 1, 1, TFF_UP, 0, 0, 0, 0));

        // Config B: non-inverting load.
        vb.push_back(mk("b_reset", 1, 1, TFF_LOAD, 0, 4'd7, 0, 0));
        vb.push_back(mk("b_load5", 0, 1, TFF_LOAD, 0, 4'd5, 5, 0));
        vb.push_back(mk("b_load_sat", 0, 1, TFF_LOAD, 0, 4'd15, 9, 0));
        vb.push_back(mk("b_wrap", 0, 1, TFF_UP, 0, 0, 0, 1));
        vb.push_back(mk("b_down", 0, 1, TFF_DOWN, 0, 0, 9, 1));

        foreach (va[i]) step(0, va[i], i);
        foreach (vb[i]) step(1, vb[i], i);

        // Config C: WIDTH=3 full-range; each cell flips iff all lower bits were 1.
        step(2, mk("c_reset", 1, 0, TFF_UP, 0, 0, 0, 0), 0);
        prev_q = 3'd0;
        for (int n = 1; n <= 9; n++) begin
            step(2, mk("c_up", 0, 1, TFF_UP, 0, 0, 4'(n % 8), (n == 8)), n);
            cur_q = if_c.q;
            for (int i = 0; i < 3; i++) begin
                exp_tog[i] = 1'b1;
                for (int j = 0; j < i; j++)
                    exp_tog[i] = exp_tog[i] & prev_q[j];
            end
            check($sformatf("c_tog[%0d]", n), 32'(prev_q ^ cur_q), 32'(exp_tog));
            prev_q = cur_q;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
